dmem_arbiter: RTL and testbench

- Shares the single-port 64-byte doubleword data memory between two requesters: req 0 = core load/store path, req 1 = debug/loader port.
- Round-robin grants; sequences each access as a fixed 3-cycle transaction on the memory's address/data/MemRead/MemWrite strobes.
- Rejects misaligned and out-of-range addresses without touching memory.
- Sits between the requesters and the data memory; owns all memory control signals.

---
 rtl/dmem_arb_pkg.sv | 15 +
 rtl/dmem_arbiter_rr_arb2.sv | 22 ++
 rtl/dmem_arbiter.sv | 158 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data-memory arbiter
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic REQ_CORE    = 1'b0;
  localparam logic REQ_DBG     = 1'b1;
  localparam int   DWORD_BYTES = 8;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rtl/dmem_arbiter_rr_arb2.sv - combinational 2-way round-robin pick
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic valid,
  output logic winner
);

  always_comb begin
    valid  = req0 | req1;
    winner = REQ_CORE;
    if (req0 && req1) begin
      winner = ~last_grant;
    end else if (req1) begin
      winner = REQ_DBG;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester arbiter for the 64-byte doubleword data memory
// Optional DMEM_ARB_STATS_EN adds saturating grant/error counters.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int MEM_BYTES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Write_Data,
  output logic              MemRead,
  output logic              MemWrite,
  input  logic [DATA_W-1:0] ReadData
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]       grant_cnt0,
  output logic [31:0]       grant_cnt1,
  output logic [15:0]       err_cnt
`endif
);

  localparam int                LSB_W     = $clog2(DWORD_BYTES);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_BYTES - DWORD_BYTES);

  state_t              state, state_n;
  logic                arb_valid, arb_winner;
  logic                load_en, cap_en;
  logic                last_grant;
  logic                id_q, we_q, legal_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [ADDR_W-1:0]   addr_sel;
  logic                legal_sel;

  rr_arb2 u_rr_arb2 (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant),
    .valid      (arb_valid),
    .winner     (arb_winner)
  );

  assign addr_sel  = arb_winner ? addr1 : addr0;
  assign legal_sel = (addr_sel[LSB_W-1:0] == '0) && (addr_sel <= LAST_ADDR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    load_en = 1'b0;
    cap_en  = 1'b0;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    rvalid0 = 1'b0;
    rvalid1 = 1'b0;
    err     = 1'b0;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    case (state)
      IDLE: begin
        if (arb_valid) begin
          load_en = 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        gnt0     = (id_q == REQ_CORE);
        gnt1     = (id_q == REQ_DBG);
        MemRead  = legal_q & ~we_q;
        MemWrite = legal_q & we_q;
        state_n  = HOLD;
      end
      HOLD: begin
        cap_en  = 1'b1;
        state_n = RESP;
      end
      RESP: begin
        rvalid0 = (id_q == REQ_CORE);
        rvalid1 = (id_q == REQ_DBG);
        err     = ~legal_q;
        // Chaining straight into ISSUE keeps back-to-back accesses at 3 cycles.
        if (arb_valid) begin
          load_en = 1'b1;
          state_n = ISSUE;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= REQ_DBG;
      id_q       <= REQ_CORE;
      we_q       <= 1'b0;
      legal_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata      <= '0;
    end else begin
      if (load_en) begin
        last_grant <= arb_winner;
        id_q       <= arb_winner;
        we_q       <= arb_winner ? we1 : we0;
        addr_q     <= addr_sel;
        wdata_q    <= arb_winner ? wdata1 : wdata0;
        legal_q    <= legal_sel;
      end
      // Stores and rejected accesses complete with zero data.
      if (cap_en) begin
        rdata <= (legal_q && !we_q) ? ReadData : '0;
      end
    end
  end

  assign Mem_Addr   = addr_q;
  assign Write_Data = wdata_q;

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
      err_cnt    <= '0;
    end else begin
      if (gnt0 && (grant_cnt0 != '1)) grant_cnt0 <= grant_cnt0 + 32'd1;
      if (gnt1 && (grant_cnt1 != '1)) grant_cnt1 <= grant_cnt1 + 32'd1;
      if ((rvalid0 || rvalid1) && err && (err_cnt != '1)) err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [63:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, err;
  logic [63:0] rdata, Mem_Addr, Write_Data, ReadData;
  logic        MemRead, MemWrite;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0] grant_cnt0, grant_cnt1;
  logic [15:0] err_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int g0_exp = 0, g1_exp = 0, e_exp = 0;

  logic [63:0] mem [8];
  logic [63:0] ref_mem [8];
  logic        mem_clr;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .err(err),
    .Mem_Addr(Mem_Addr), .Write_Data(Write_Data),
    .MemRead(MemRead), .MemWrite(MemWrite), .ReadData(ReadData)
`ifdef DMEM_ARB_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .err_cnt(err_cnt)
`endif
  );

  // Synchronous-read memory: data appears the cycle after MemRead.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 8; i++) mem[i] <= 64'd0;
    end else begin
      if (MemWrite) mem[Mem_Addr[5:3]] <= Write_Data;
      if (MemRead) ReadData <= mem[Mem_Addr[5:3]];
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if ((gnt0 && gnt1) || (rvalid0 && rvalid1) || (MemRead && MemWrite)) begin
        errors++;
        $display("FAIL exclusive gnt=%b%b rvalid=%b%b strobes=%b%b required one-hot",
                 gnt1, gnt0, rvalid1, rvalid0, MemWrite, MemRead);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic is_legal(input logic [63:0] a);
    return (a % 8 == 0) && (a <= 64'd56);
  endfunction

  task automatic do_access(input logic id, input logic we, input logic [63:0] addr,
                           input logic [63:0] wdata, input logic [63:0] exp_rdata,
                           input logic exp_err, input string name);
    int   cyc;
    logic legal;
    logic seen;
    legal = is_legal(addr);
    @(negedge clk);
    if (id) begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata; end
    else    begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata; end
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!(id ? gnt1 : gnt0) && cyc < 20);
    seen = id ? gnt1 : gnt0;
    chk({name, " gnt_latency"}, 64'(cyc), 64'd1);
    chk({name, " other_gnt"}, 64'(id ? gnt0 : gnt1), 64'd0);
    chk({name, " MemWrite"}, 64'(MemWrite), 64'(legal && we));
    chk({name, " MemRead"}, 64'(MemRead), 64'(legal && !we));
    chk({name, " Mem_Addr"}, Mem_Addr, addr);
    if (we) chk({name, " Write_Data"}, Write_Data, wdata);
    if (seen) begin if (id) g1_exp++; else g0_exp++; end
    if (id) req1 = 1'b0; else req0 = 1'b0;
    if (legal && we) ref_mem[addr[5:3]] = wdata;
    @(negedge clk);
    chk({name, " hold_strobes"}, 64'({MemRead, MemWrite}), 64'd0);
    chk({name, " hold_addr"}, Mem_Addr, addr);
    cyc = 1;
    while (!(id ? rvalid1 : rvalid0) && cyc < 20) begin @(negedge clk); cyc++; end
    seen = id ? rvalid1 : rvalid0;
    chk({name, " rvalid_latency"}, 64'(cyc + 1), 64'd3);
    chk({name, " other_rvalid"}, 64'(id ? rvalid0 : rvalid1), 64'd0);
    chk({name, " err"}, 64'(err), 64'(exp_err));
    chk({name, " rdata"}, rdata, exp_rdata);
    if (seen && exp_err) e_exp++;
  endtask

  typedef struct {
    logic        id;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int ng, nr;
    logic [63:0] a, d, e;
    logic w, r;

    vecs[0] = '{1'b0, 1'b1, 64'h08, 64'h1122334455667788, 64'h0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 64'h08, 64'h0, 64'h1122334455667788, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 64'h0C, 64'h0, 64'h0, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 64'h40, 64'h0, 64'h0, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 64'h38, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 64'h38, 64'h0, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 64'h41, 64'hDEAD, 64'h0, 1'b1};

    for (int i = 0; i < 8; i++) ref_mem[i] = 64'd0;
    reset = 1'b1; mem_clr = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    repeat (3) @(negedge clk);
    chk("reset gnt/rvalid", 64'({gnt0, gnt1, rvalid0, rvalid1}), 64'd0);
    chk("reset strobes/err", 64'({MemRead, MemWrite, err}), 64'd0);
    chk("reset Mem_Addr", Mem_Addr, 64'd0);
    chk("reset Write_Data", Write_Data, 64'd0);
    chk("reset rdata", rdata, 64'd0);
    reset = 1'b0; mem_clr = 1'b0;

    for (int i = 0; i < 7; i++)
      do_access(vecs[i].id, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                vecs[i].exp_rdata, vecs[i].exp_err, $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      r = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        8: a = 64'($urandom_range(0, 7) * 8 + $urandom_range(1, 7));
        9: a = 64'(64 + $urandom_range(0, 1000));
        default: a = 64'($urandom_range(0, 7) * 8);
      endcase
      d = {$urandom, $urandom};
      if (!is_legal(a)) e = 64'd0;
      else if (w) e = 64'd0;
      else e = ref_mem[a[5:3]];
      do_access(r, w, a, d, e, !is_legal(a), $sformatf("rnd%0d", i));
    end

    // Both requesters held from reset: alternating grants every 3 cycles.
    @(negedge clk);
    reset = 1'b1;
    req0 = 1; we0 = 0; addr0 = 64'h00;
    req1 = 1; we1 = 0; addr1 = 64'h38;
    @(negedge clk);
    reset = 1'b0;
    g0_exp = 0; g1_exp = 0; e_exp = 0;
    ng = 0; nr = 0;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin
        chk($sformatf("rr gnt%0d id", ng), 64'(gnt1), 64'(ng % 2));
        chk($sformatf("rr gnt%0d cycle", ng), 64'(cyc), 64'(1 + 3 * ng));
        if (gnt1) g1_exp++; else g0_exp++;
        ng++;
        if (ng == 4) begin req0 = 0; req1 = 0; end
      end
      if (rvalid0 || rvalid1) begin
        chk($sformatf("rr rvalid%0d id", nr), 64'(rvalid1), 64'(nr % 2));
        chk($sformatf("rr rvalid%0d cycle", nr), 64'(cyc), 64'(3 + 3 * nr));
        chk($sformatf("rr rvalid%0d rdata", nr), rdata, rvalid1 ? ref_mem[7] : ref_mem[0]);
        chk($sformatf("rr rvalid%0d err", nr), 64'(err), 64'd0);
        nr++;
      end
    end
    chk("rr grant count", 64'(ng), 64'd4);
    chk("rr rvalid count", 64'(nr), 64'd4);

    // Reset during HOLD aborts the load without a completion.
    @(negedge clk);
    req0 = 1; we0 = 0; addr0 = 64'h08;
    @(negedge clk);
    chk("abort gnt0", 64'(gnt0), 64'd1);
    req0 = 0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort outputs", 64'({gnt0, gnt1, rvalid0, rvalid1, MemRead, MemWrite, err}), 64'd0);
    chk("abort Mem_Addr", Mem_Addr, 64'd0);
    chk("abort Write_Data", Write_Data, 64'd0);
    chk("abort rdata", rdata, 64'd0);
    reset = 1'b0;
    g0_exp = 0; g1_exp = 0; e_exp = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort no rvalid", 64'({rvalid0, rvalid1}), 64'd0);
    end

    for (int k = 0; k < 5; k++)
      do_access(1'b0, 1'b0, 64'(k * 8), 64'd0, ref_mem[k], 1'b0, $sformatf("post%0d", k));
    do_access(1'b1, 1'b0, 64'h38, 64'd0, ref_mem[7], 1'b0, "post_d0");
    do_access(1'b1, 1'b0, 64'h10, 64'd0, ref_mem[2], 1'b0, "post_d1");
    do_access(1'b1, 1'b0, 64'h0C, 64'd0, 64'd0, 1'b1, "post_d2");

`ifdef DMEM_ARB_STATS_EN
    @(negedge clk);
    chk("grant_cnt0", 64'(grant_cnt0), 64'(g0_exp));
    chk("grant_cnt1", 64'(grant_cnt1), 64'(g1_exp));
    chk("err_cnt", 64'(err_cnt), 64'(e_exp));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
